// File: rtl/pd_hyst_pdw_if.sv
// pd_hyst_pdw_if: PDW output handshake bundle between detector and downstream sorter
interface pd_hyst_pdw_if #(
  parameter int VIDEO_SIZE = 10,
  parameter int TIME_SIZE = 32,
  parameter int CNT_SIZE = 16
);
  logic valid;
  logic ready;
  logic [TIME_SIZE-1:0] toa;
  logic [TIME_SIZE-1:0] pw;
  logic [VIDEO_SIZE-1:0] pa;
  logic [TIME_SIZE-1:0] pri;
  logic [CNT_SIZE-1:0] seq;
  logic trunc;
  modport master(output valid, toa, pw, pa, pri, seq, trunc, input ready);
  modport slave(input valid, toa, pw, pa, pri, seq, trunc, output ready);
endinterface

// File: rtl/pd_hyst_pdw.sv
// pd_hyst_pdw: hysteresis pulse detector with glitch filter, CW truncation and PDW output register
module pd_hyst_pdw #(
  parameter int VIDEO_SIZE = 10,
  parameter int TIME_SIZE = 32,
  parameter int CNT_SIZE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic [VIDEO_SIZE-1:0] video,
  input  logic [VIDEO_SIZE-1:0] thr_high,
  input  logic [VIDEO_SIZE-1:0] thr_low,
  input  logic [TIME_SIZE-1:0] min_pw,
  input  logic [TIME_SIZE-1:0] max_pw,
  pd_hyst_pdw_if.master pdw,
  output logic [CNT_SIZE-1:0] drop_count
);
  typedef enum logic [1:0] {IDLE, ACTIVE, CW_WAIT} state_t;
  state_t state, state_nx;
  logic [TIME_SIZE-1:0] time_r, toa_r, last_toa, dur, pw_end;
  logic [VIDEO_SIZE-1:0] pa_r, lo_eff;
  logic [CNT_SIZE-1:0] seq_r;
  logic first, start, end_fall, end_cw, cw_exit, accept, load;
  always_comb begin
    lo_eff = thr_low < thr_high ? thr_low : thr_high;
    dur = time_r - toa_r;
    start = enable && state == IDLE && video >= thr_high;
    end_fall = enable && state == ACTIVE && video < lo_eff;
    end_cw = enable && state == ACTIVE && !end_fall && max_pw != '0 && dur == max_pw;
    cw_exit = enable && state == CW_WAIT && video < lo_eff;
    pw_end = end_cw ? max_pw : dur;
    accept = (end_fall || end_cw) && !(min_pw != '0 && pw_end < min_pw);
    load = accept && (!pdw.valid || pdw.ready);
    state_nx = start ? ACTIVE : end_fall ? IDLE : end_cw ? CW_WAIT : cw_exit ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      time_r <= '0;
      toa_r <= '0;
      pa_r <= '0;
      last_toa <= '0;
      first <= 1'b1;
      seq_r <= '0;
      pdw.valid <= 1'b0;
      pdw.toa <= '0;
      pdw.pw <= '0;
      pdw.pa <= '0;
      pdw.pri <= '0;
      pdw.seq <= '0;
      pdw.trunc <= 1'b0;
      drop_count <= '0;
    end else begin
      if (enable) time_r <= time_r + 1'b1;
      if (start) begin
        toa_r <= time_r;
        pa_r <= video;
      end else if (enable && state == ACTIVE && !end_fall && !end_cw && video > pa_r) pa_r <= video;
      if (accept) begin
        last_toa <= toa_r;
        first <= 1'b0;
        seq_r <= seq_r + 1'b1;
      end
      if (load) begin
        pdw.valid <= 1'b1;
        pdw.toa <= toa_r;
        pdw.pw <= pw_end;
        pdw.pa <= pa_r;
        pdw.pri <= first ? '0 : toa_r - last_toa;
        pdw.seq <= seq_r;
        pdw.trunc <= end_cw;
      end else if (pdw.valid && pdw.ready) pdw.valid <= 1'b0;
      // a full, unconsumed register loses the word; seq has already advanced
      if (accept && !load && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
endmodule

// File: tb/tb_pd_hyst_pdw.sv
// tb_pd_hyst_pdw: directed bench with a sample-history pulse model checked every cycle
module tb_pd_hyst_pdw;
  localparam int V = 10, T = 32, C = 16;
  logic clock = 0, reset = 1, enable = 0;
  logic [V-1:0] video = 0, thr_high = 100, thr_low = 80;
  logic [T-1:0] min_pw = 0, max_pw = 0;
  logic [C-1:0] drop_count;
  int n_chk = 0, n_fail = 0;
  pd_hyst_pdw_if #(.VIDEO_SIZE(V), .TIME_SIZE(T), .CNT_SIZE(C)) pdw();
  pd_hyst_pdw #(.VIDEO_SIZE(V), .TIME_SIZE(T), .CNT_SIZE(C)) dut (
    .clock(clock), .reset(reset), .enable(enable), .video(video),
    .thr_high(thr_high), .thr_low(thr_low), .min_pw(min_pw), .max_pw(max_pw),
    .pdw(pdw), .drop_count(drop_count)
  );
  always #5 clock = ~clock;

  logic [T-1:0] mt, mtoa, mlast;
  bit m_in, m_cw, mfirst;
  logic [C-1:0] mseq;
  logic [V-1:0] hist[$];
  bit e_valid, e_trunc;
  logic [T-1:0] e_toa, e_pw, e_pri;
  logic [V-1:0] e_pa;
  logic [C-1:0] e_seq, e_drop;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    mt = 0; mtoa = 0; mlast = 0; m_in = 0; m_cw = 0; mfirst = 1; mseq = 0;
    hist.delete();
    e_valid = 0; e_trunc = 0; e_toa = 0; e_pw = 0; e_pri = 0; e_pa = 0; e_seq = 0; e_drop = 0;
  endtask

  task automatic step(input logic [V-1:0] v, input bit en = 1);
    bit acc, tr, consumed;
    logic [T-1:0] w, pwm, pri;
    logic [V-1:0] lo, pk;
    logic [C-1:0] sq;
    acc = 0; tr = 0; pwm = 0; pk = 0; pri = 0; sq = 0;
    video = v; enable = en;
    lo = thr_low < thr_high ? thr_low : thr_high;
    consumed = e_valid && pdw.ready;
    if (en) begin
      if (m_in) begin
        w = mt - mtoa;
        if (v < lo) begin acc = 1; pwm = w; m_in = 0; end
        else if (max_pw != 0 && w == max_pw) begin acc = 1; pwm = max_pw; tr = 1; m_in = 0; m_cw = 1; end
        else hist.push_back(v);
      end else if (m_cw) begin
        if (v < lo) m_cw = 0;
      end else if (v >= thr_high) begin
        m_in = 1; mtoa = mt; hist = {v};
      end
      mt = mt + 1;
    end
    if (acc && min_pw != 0 && pwm < min_pw) acc = 0;
    if (acc) begin
      foreach (hist[i]) if (hist[i] > pk) pk = hist[i];
      pri = mfirst ? 0 : mtoa - mlast;
      mlast = mtoa; mfirst = 0; sq = mseq; mseq = mseq + 1;
    end
    @(posedge clock);
    #1;
    if (acc && (!e_valid || consumed)) begin
      e_valid = 1; e_toa = mtoa; e_pw = pwm; e_pa = pk; e_pri = pri; e_seq = sq; e_trunc = tr;
    end else if (acc) begin
      if (e_drop != '1) e_drop = e_drop + 1;
    end else if (consumed) e_valid = 0;
  endtask

  task automatic run(input logic [V-1:0] v, input int n);
    repeat (n) step(v);
  endtask

  task automatic lit(input string nm, input int toa, pw, pa, pri, seq, trunc);
    chk({nm, "_valid"}, pdw.valid, 1);
    chk({nm, "_toa"}, pdw.toa, toa);
    chk({nm, "_pw"}, pdw.pw, pw);
    chk({nm, "_pa"}, pdw.pa, pa);
    chk({nm, "_pri"}, pdw.pri, pri);
    chk({nm, "_seq"}, pdw.seq, seq);
    chk({nm, "_trunc"}, pdw.trunc, trunc);
    chk({nm, "_model_toa"}, e_toa, toa);
    chk({nm, "_model_pw"}, e_pw, pw);
    chk({nm, "_model_pa"}, e_pa, pa);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, pdw.valid, 0);
    chk({nm, "_toa"}, pdw.toa, 0);
    chk({nm, "_pw"}, pdw.pw, 0);
    chk({nm, "_pa"}, pdw.pa, 0);
    chk({nm, "_pri"}, pdw.pri, 0);
    chk({nm, "_seq"}, pdw.seq, 0);
    chk({nm, "_trunc"}, pdw.trunc, 0);
    chk({nm, "_drop"}, drop_count, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    @(posedge clock);
    #1 reset = 0;
  endtask

  always @(negedge clock)
    if (!reset) begin
      chk("cyc_valid", pdw.valid, e_valid);
      chk("cyc_drop", drop_count, e_drop);
      if (e_valid) begin
        chk("cyc_toa", pdw.toa, e_toa);
        chk("cyc_pw", pdw.pw, e_pw);
        chk("cyc_pa", pdw.pa, e_pa);
        chk("cyc_pri", pdw.pri, e_pri);
        chk("cyc_seq", pdw.seq, e_seq);
        chk("cyc_trunc", pdw.trunc, e_trunc);
      end
    end

  initial begin
    pdw.ready = 1;
    model_reset();
    #1 chk_zero("reset0");
    do_reset();
    // basic pulse
    run(0, 5); run(120, 1); run(150, 1); run(90, 2); run(70, 1);
    lit("basic", 5, 4, 150, 0, 0, 0);
    // hysteresis dip plus a disabled cycle mid-pulse
    run(120, 3); step(0, 0); run(90, 2); run(120, 2); run(0, 1);
    lit("hyst", 10, 7, 120, 5, 1, 0);
    step(0);
    chk("hyst_single", pdw.valid, 0);
    // thr_low above thr_high falls back to thr_high
    thr_low = 150;
    run(120, 2); run(110, 1); run(90, 1);
    lit("loeff", 19, 3, 120, 9, 2, 0);
    thr_low = 80;
    // glitch filter
    do_reset();
    min_pw = 3;
    run(0, 10); run(120, 2); run(0, 1);
    chk("discard", pdw.valid, 0);
    run(0, 27); run(120, 5); run(0, 1);
    lit("minpw2", 40, 5, 120, 0, 0, 0);
    run(0, 54); run(120, 3); run(0, 1);
    lit("minpw3", 100, 3, 120, 60, 1, 0);
    // CW truncation
    do_reset();
    min_pw = 0; max_pw = 8;
    run(0, 20); run(200, 9);
    lit("cw", 20, 8, 200, 0, 0, 1);
    run(200, 41);
    chk("cw_wait", pdw.valid, 0);
    step(0); run(200, 3); step(0);
    lit("cw_after", 71, 3, 200, 51, 1, 0);
    max_pw = 0;
    // backpressure and drops
    do_reset();
    pdw.ready = 0;
    run(0, 2); run(120, 2); run(0, 1);
    run(120, 2); run(0, 1);
    run(120, 2); run(0, 1);
    lit("held", 2, 2, 120, 0, 0, 0);
    chk("drops", drop_count, 2);
    run(120, 2);
    pdw.ready = 1;
    step(0);
    lit("b2b", 11, 2, 120, 3, 3, 0);
    // async reset while active with a word held
    pdw.ready = 0;
    run(120, 2); run(0, 1); run(120, 2);
    chk("pre_rst_valid", pdw.valid, 1);
    #2 reset = 1;
    #1 chk_zero("async_rst");
    model_reset();
    @(posedge clock);
    #1 reset = 0;
    pdw.ready = 1;
    run(0, 3); run(120, 2); run(0, 1);
    lit("post_rst", 3, 2, 120, 0, 0, 0);
    run(0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
